ifm_window_gen: RTL and testbench

IFM_WINDOW_GEN -- requirements
Module: ifm_window_gen

---
 rtl/cnn_pkg.sv | 10 +
 rtl/ifm_window_gen_if.sv | 39 +++
 rtl/line_buf.sv | 33 +++
 rtl/ifm_window_gen.sv | 130 +++++++++++++
 tb/tb_ifm_window_gen.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/cnn_pkg.sv
// rtl/cnn_pkg.sv - shared CNN constants and pixel type for the window generator
package cnn_pkg;

    localparam int WIN_K       = 3;
    localparam int PE_ARR_SIZE = WIN_K * WIN_K;
    localparam int PIX_W       = 8;

    typedef logic signed [PIX_W-1:0] pixel_t;

endpackage

// File: rtl/ifm_window_gen_if.sv
// rtl/ifm_window_gen_if.sv - pixel-in / window-out bus of the window generator
//
// Signals:
//   pix_valid   pixel source -> generator, pix_input valid this cycle
//   pix_input   pixel source -> generator, signed raster-order pixel
//   win_valid   generator -> consumer, ifm_output holds a complete window
//   ifm_output  generator -> consumer, 3x3 window row-major, [0] top-left
//   frame_done  generator -> consumer, pulse after the last pixel of a frame
// Modports: master (pixel source / window sink), slave (the generator).
interface ifm_window_gen_if
    import cnn_pkg::*;
#(
    parameter int W = PIX_W,
    parameter int N = PE_ARR_SIZE
);

    logic                pix_valid;
    logic signed [W-1:0] pix_input;
    logic                win_valid;
    logic signed [W-1:0] ifm_output [N];
    logic                frame_done;

    modport master (
        output pix_valid,
        output pix_input,
        input  win_valid,
        input  ifm_output,
        input  frame_done
    );

    modport slave (
        input  pix_valid,
        input  pix_input,
        output win_valid,
        output ifm_output,
        output frame_done
    );

endinterface

// File: rtl/line_buf.sv
// rtl/line_buf.sv - DEPTH-deep pixel shift buffer advancing only when en is high
//
// Ports:
//   clk   rising-edge clock
//   en    shift enable (accepted pixel)
//   din   pixel shifted in
//   dout  pixel shifted in DEPTH accepted pixels ago
// Storage is deliberately not reset: the generator's row counter keeps any
// stale content away from the outputs until it has been overwritten.
module line_buf #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                    clk,
    input  logic                    en,
    input  logic signed [WIDTH-1:0] din,
    output logic signed [WIDTH-1:0] dout
);

    logic signed [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            mem[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                mem[i] <= mem[i-1];
            end
        end
    end

    assign dout = mem[DEPTH-1];

endmodule

// File: rtl/ifm_window_gen.sv
// rtl/ifm_window_gen.sv - 3x3 sliding-window generator over a raster pixel stream
//
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-high reset
//   bus   ifm_window_gen_if.slave: pix_valid/pix_input in,
//         win_valid/ifm_output/frame_done out
// Optional build macro IFM_WIN_STRIDE2_EN: emit windows at stride 2 in both
// directions instead of stride 1; frame_done is unaffected.
module ifm_window_gen #(
    parameter int INPUT_IFM_WIDTH = cnn_pkg::PIX_W,
    parameter int IFM_COLS        = 8,
    parameter int IFM_ROWS        = 8,
    parameter int PE_ARR_SIZE     = cnn_pkg::PE_ARR_SIZE
) (
    input  logic           clk,
    input  logic           rst,
    ifm_window_gen_if.slave bus
);

    localparam int K  = cnn_pkg::WIN_K;
    localparam int CW = (IFM_COLS > 1) ? $clog2(IFM_COLS) : 1;
    localparam int RW = (IFM_ROWS > 1) ? $clog2(IFM_ROWS) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(IFM_COLS - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IFM_ROWS - 1);

    typedef logic signed [INPUT_IFM_WIDTH-1:0] pix_t;

    logic [CW-1:0] col_cnt;
    logic [RW-1:0] row_cnt;
    logic          accept;
    logic          col_last;
    logic          row_last;
    logic          win_pos;
    pix_t          lb0_out;
    pix_t          lb1_out;
    pix_t          win_q [K][K];
    pix_t          win_d [K][K];

    assign accept   = bus.pix_valid;
    assign col_last = (col_cnt == COL_LAST);
    assign row_last = (row_cnt == ROW_LAST);

    // Line 0 holds the previous row, line 1 the row before it; chaining them
    // means each output lines up with the current column of older rows.
    line_buf #(
        .WIDTH (INPUT_IFM_WIDTH),
        .DEPTH (IFM_COLS)
    ) u_line0 (
        .clk  (clk),
        .en   (accept),
        .din  (bus.pix_input),
        .dout (lb0_out)
    );

    line_buf #(
        .WIDTH (INPUT_IFM_WIDTH),
        .DEPTH (IFM_COLS)
    ) u_line1 (
        .clk  (clk),
        .en   (accept),
        .din  (lb0_out),
        .dout (lb1_out)
    );

    // A window is complete only once two full rows and two columns of the
    // current frame precede the newest pixel; this also hides whatever the
    // line buffers still hold from an earlier frame.
    always_comb begin
        win_pos = (row_cnt >= RW'(2)) && (col_cnt >= CW'(2));
`ifdef IFM_WIN_STRIDE2_EN
        // (row-2) and (col-2) even is the same as row and col even.
        win_pos = win_pos && !row_cnt[0] && !col_cnt[0];
`endif
    end

    // Next window: shift every row left, new right column from the buffers.
    always_comb begin
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K - 1; c++) begin
                win_d[r][c] = win_q[r][c+1];
            end
        end
        win_d[0][K-1] = lb1_out;
        win_d[1][K-1] = lb0_out;
        win_d[2][K-1] = bus.pix_input;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_cnt        <= '0;
            row_cnt        <= '0;
            bus.win_valid  <= 1'b0;
            bus.frame_done <= 1'b0;
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K; c++) begin
                    win_q[r][c] <= '0;
                end
            end
            for (int i = 0; i < PE_ARR_SIZE; i++) begin
                bus.ifm_output[i] <= '0;
            end
        end else begin
            bus.win_valid  <= accept && win_pos;
            bus.frame_done <= accept && col_last && row_last;
            if (accept) begin
                if (col_last) begin
                    col_cnt <= '0;
                    row_cnt <= row_last ? '0 : row_cnt + RW'(1);
                end else begin
                    col_cnt <= col_cnt + CW'(1);
                end
                for (int r = 0; r < K; r++) begin
                    for (int c = 0; c < K; c++) begin
                        win_q[r][c] <= win_d[r][c];
                    end
                end
                // Output only moves on a real window so it holds otherwise.
                if (win_pos) begin
                    for (int r = 0; r < K; r++) begin
                        for (int c = 0; c < K; c++) begin
                            bus.ifm_output[r*K+c] <= win_d[r][c];
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ifm_window_gen.sv
// tb/tb_ifm_window_gen.sv - self-checking bench for ifm_window_gen
module tb_ifm_window_gen;
    import cnn_pkg::*;

    localparam int COLS = 4;
    localparam int ROWS = 4;
`ifdef IFM_WIN_STRIDE2_EN
    localparam int EXP_WIN = ((ROWS - 1) / 2) * ((COLS - 1) / 2);
`else
    localparam int EXP_WIN = (ROWS - 2) * (COLS - 2);
`endif
    localparam int PW = PE_ARR_SIZE * PIX_W;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    ifm_window_gen_if #(.W(PIX_W), .N(PE_ARR_SIZE)) bus ();

    ifm_window_gen #(
        .INPUT_IFM_WIDTH (PIX_W),
        .IFM_COLS        (COLS),
        .IFM_ROWS        (ROWS),
        .PE_ARR_SIZE     (PE_ARR_SIZE)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Reference model: the frame as a 2-D image plus a raster position.
    pixel_t img [ROWS][COLS];
    int     mrow;
    int     mcol;
    pixel_t exp_out [PE_ARR_SIZE];
    logic   exp_wv;
    logic   exp_fd;

    int passed = 0;
    int total  = 0;
    int win_seen;
    int done_seen;

    pixel_t ref_a [PE_ARR_SIZE];

    function automatic logic model_pos(input int r, input int c);
        logic p;
        p = (r >= 2) && (c >= 2);
`ifdef IFM_WIN_STRIDE2_EN
        p = p && ((r - 2) % 2 == 0) && ((c - 2) % 2 == 0);
`endif
        return p;
    endfunction

    function automatic logic [PW-1:0] pack_dut();
        logic [PW-1:0] v;
        for (int i = 0; i < PE_ARR_SIZE; i++) v[i*PIX_W +: PIX_W] = bus.ifm_output[i];
        return v;
    endfunction

    function automatic logic [PW-1:0] pack_arr(input pixel_t a [PE_ARR_SIZE]);
        logic [PW-1:0] v;
        for (int i = 0; i < PE_ARR_SIZE; i++) v[i*PIX_W +: PIX_W] = a[i];
        return v;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        mrow   = 0;
        mcol   = 0;
        exp_wv = 1'b0;
        exp_fd = 1'b0;
        for (int i = 0; i < PE_ARR_SIZE; i++) exp_out[i] = '0;
    endtask

    // One clock: drive, advance the model, then sample 1 time unit after the edge.
    task automatic step(input logic v, input pixel_t p);
        bus.pix_valid = v;
        bus.pix_input = p;
        exp_wv = 1'b0;
        exp_fd = 1'b0;
        if (v) begin
            img[mrow][mcol] = p;
            exp_wv = model_pos(mrow, mcol);
            if (exp_wv) begin
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++)
                        exp_out[i*3+j] = img[mrow-2+i][mcol-2+j];
            end
            exp_fd = (mrow == ROWS - 1) && (mcol == COLS - 1);
            mcol++;
            if (mcol == COLS) begin
                mcol = 0;
                mrow = (mrow == ROWS - 1) ? 0 : mrow + 1;
            end
        end
        @(posedge clk);
        #1;
        chk("win_valid", 128'(bus.win_valid), 128'(exp_wv));
        chk("frame_done", 128'(bus.frame_done), 128'(exp_fd));
        chk("ifm_output", 128'(pack_dut()), 128'(pack_arr(exp_out)));
        if (bus.win_valid) win_seen++;
        if (bus.frame_done) done_seen++;
        bus.pix_valid = 1'b0;
    endtask

    task automatic run_frame(input int base, input bit toggle);
        win_seen  = 0;
        done_seen = 0;
        for (int k = 0; k < ROWS * COLS; k++) begin
            if (toggle) step(1'b0, pixel_t'($urandom));
            step(1'b1, pixel_t'(base + k));
        end
        chk("win_count", 128'(win_seen), 128'(EXP_WIN));
        chk("done_count", 128'(done_seen), 128'(1));
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_win_valid"}, 128'(bus.win_valid), 128'(0));
        chk({tag, "_frame_done"}, 128'(bus.frame_done), 128'(0));
        chk({tag, "_ifm_output"}, 128'(pack_dut()), 128'(0));
    endtask

    initial begin
        rst           = 1'b1;
        bus.pix_valid = 1'b0;
        bus.pix_input = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_zero_outputs("reset");
        rst = 1'b0;

        // 4x4 frame, continuous valid; explicit first window after pixel 10.
        win_seen  = 0;
        done_seen = 0;
        for (int k = 0; k <= 10; k++) step(1'b1, pixel_t'(k));
        ref_a = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
        chk("first_window", 128'(pack_dut()), 128'(pack_arr(ref_a)));
        chk("first_window_valid", 128'(bus.win_valid), 128'(1));
        for (int k = 11; k < 16; k++) step(1'b1, pixel_t'(k));
        chk("win_count", 128'(win_seen), 128'(EXP_WIN));
        chk("done_count", 128'(done_seen), 128'(1));

        // Same frame with stalls between every pixel.
        run_frame(0, 1'b1);

        // Back-to-back frames; second frame must not see first-frame data.
        run_frame(0, 1'b0);
        for (int k = 0; k <= 10; k++) step(1'b1, pixel_t'(100 + k));
        ref_a = '{100, 101, 102, 104, 105, 106, 108, 109, 110};
        chk("frame2_first_window", 128'(pack_dut()), 128'(pack_arr(ref_a)));
        for (int k = 11; k < 16; k++) step(1'b1, pixel_t'(100 + k));

        // Reset mid-frame, checked asynchronously before any clock edge.
        for (int k = 0; k < 7; k++) step(1'b1, pixel_t'(50 + k));
        rst = 1'b1;
        #1;
        check_zero_outputs("async_reset");
        repeat (2) @(posedge clk);
        #1;
        check_zero_outputs("held_reset");
        rst = 1'b0;
        model_reset();
        run_frame(0, 1'b0);

        // Signed extremes.
        win_seen  = 0;
        done_seen = 0;
        for (int k = 0; k < ROWS * COLS; k++) step(1'b1, (k % 2 == 1) ? pixel_t'(127) : pixel_t'(-128));
        chk("extreme_win_count", 128'(win_seen), 128'(EXP_WIN));

        // Randomized frames with random stalls and occasional extremes.
        for (int f = 0; f < 4; f++) begin
            win_seen  = 0;
            done_seen = 0;
            for (int k = 0; k < ROWS * COLS; k++) begin
                pixel_t p;
                int     sel;
                while ($urandom_range(0, 3) == 0) step(1'b0, pixel_t'($urandom));
                sel = int'($urandom_range(0, 5));
                p = (sel == 0) ? pixel_t'(-128) : (sel == 1) ? pixel_t'(127) : pixel_t'($urandom);
                step(1'b1, p);
            end
            chk("rand_win_count", 128'(win_seen), 128'(EXP_WIN));
            chk("rand_done_count", 128'(done_seen), 128'(1));
        end

        // Stall cycles after the frame must keep outputs quiet and held.
        for (int k = 0; k < 3; k++) step(1'b0, pixel_t'($urandom));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
